haze_gain_ramp_ctrl: RTL and testbench
======================================

Name: haze_gain_ramp_ctrl

Overview:
Bus-programmable gain scheduler for the two-channel haze gain stage (dat_i*kp + dat2_i*kp2). It holds the live gain pair that drives the multiplier datapath. On command it ramps both gains in bounded steps toward programmed targets, instead of jumping, so the analog output sees no step transients. It sits between the PS system bus and the haze datapath gain inputs, sharing the bus protocol (addr/wen/ren/ack/rdata/wdata).

Parameters:
GAINBITS, 24, signed width of each gain (two's complement)
DEFAULT_INTERVAL, 1000, reset value of the step-interval register in clk_i cycles

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
addr  in  16  bus address
wen  in  1  bus write strobe
ren  in  1  bus read strobe
wdata  in  32  bus write data
ack  out  1  bus acknowledge, registered
rdata  out  32  bus read data, registered
kp_o  out  GAINBITS  live gain, channel 1, signed
kp2_o  out  GAINBITS  live gain, channel 2, signed
busy_o  out  1  ramp in progress
done_o  out  1  sticky: last ramp reached target
upd_o  out  1  one-cycle pulse on the cycle kp_o/kp2_o change

Behaviour:
- Reset: single clock domain, clk_i; reset asynchronous, active-high, on rst_i. All registers clear asynchronously: targets=0, step=0, interval=DEFAULT_INTERVAL, kp_o=kp2_o=0, busy_o=0, done_o=0, upd_o=0, ack=0, rdata=0, state=IDLE. Reset mid-ramp aborts the ramp immediately.
- Register map (read/write unless noted; gains sign-extended on read):
  - 0x100 tgt_kp
  - 0x104 tgt_kp2
  - 0x108 step, unsigned, GAINBITS-1 bits
  - 0x10C interval, 32 bit
  - 0x110 ctrl: bit0 start (W1 pulse), bit1 abort (W1 pulse), bit2 hold (level); reads back hold only
  - 0x114 status, RO: bit0 busy, bit1 done
  - 0x118 kp_o, RO
  - 0x11C kp2_o, RO
- Bus: ack <= wen|ren on every clock, registered; rdata is valid in the same cycle as ack. Unmapped addresses read 0, and writes to them are ignored.
- Effective interval I = max(interval,1).
- FSM states: IDLE, WAIT, STEP.
  - IDLE + start: if kp_o==tgt_kp and kp2_o==tgt_kp2, set done=1 and stay IDLE. Otherwise load cnt=I, clear done, go WAIT.
  - WAIT: if hold=0, cnt decrements each cycle; when cnt==1 and hold=0, go STEP. hold=1 freezes cnt and outputs.
  - STEP (1 cycle): update both gains. Each gain moves toward its target by min(step,|tgt-cur|), so it never overshoots. Difference arithmetic uses GAINBITS+1 bits, so no wrap. step==0 means jump directly to target. upd_o=1 if either gain changed. If both now equal their targets, set done=1 and go IDLE. Otherwise reload cnt=I and go WAIT.
  - Gain update period is I+1 cycles. The first update occurs I+1 cycles after the edge that accepts the start write.
  - busy_o=1 in WAIT and STEP.
- abort (any state) has priority over start in the same write. It goes to IDLE next cycle, kp_o/kp2_o keep their current values, done stays 0.
- start while busy restarts the ramp: cnt reloads to I and the current gains are kept.
- Target and step writes during a ramp take effect at the next STEP.
- Writes to kp_o/kp2_o addresses are ignored; live gains change only via STEP.

Test Plan:
- Positive ramp: tgt_kp=100, step=30, interval=4, start from 0 -> kp_o = 30, 60, 90, 100 at 5, 10, 15, 20 cycles after start; upd_o pulses 4 times; done_o=1 and busy_o=0 after the 4th update.
- Negative/mixed ramp: tgt_kp=10, tgt_kp2=-50, step=20, interval=1 -> kp_o 10, 10, 10; kp2_o -20, -40, -50 every 2 cycles; done after 3rd update; no overshoot.
- Extremes: kp_o=-8388608 at start, tgt_kp=8388607, step=8388607 -> kp_o = -1, 8388606, 8388607; no wrap.
- Hold and abort: during ramp set hold=1 for 10 cycles -> no updates and cnt frozen; clear hold -> ramp resumes. Write abort -> busy_o=0 next cycle, gains retained, done_o=0.
- Asynchronous reset mid-WAIT: assert rst_i between clock edges -> kp_o=0, busy_o=0, interval reads 1000, ack=0 without waiting for a clock edge.
- Bus: read 0x114 while busy -> rdata=1 with ack one cycle after ren. Start with gains already at target -> done_o=1 next cycle, busy_o never asserts. Read of an unmapped address -> 0.

Source files
------------

// File: rtl/haze_gain_ramp_ctrl.sv
// Bus-programmable gain scheduler for the two-channel haze gain stage.
// Ramps kp/kp2 toward programmed targets in bounded steps, one step every I+1 cycles.
module haze_gain_ramp_ctrl #(
    parameter int GAINBITS         = 24,
    parameter int DEFAULT_INTERVAL = 1000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [15:0]                addr,
    input  logic                       wen,
    input  logic                       ren,
    input  logic [31:0]                wdata,
    output logic                       ack,
    output logic [31:0]                rdata,
    output logic signed [GAINBITS-1:0] kp_o,
    output logic signed [GAINBITS-1:0] kp2_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       upd_o
);

    localparam logic [15:0] ADDR_TGT_KP  = 16'h0100;
    localparam logic [15:0] ADDR_TGT_KP2 = 16'h0104;
    localparam logic [15:0] ADDR_STEP    = 16'h0108;
    localparam logic [15:0] ADDR_IVAL    = 16'h010C;
    localparam logic [15:0] ADDR_CTRL    = 16'h0110;
    localparam logic [15:0] ADDR_STATUS  = 16'h0114;
    localparam logic [15:0] ADDR_KP      = 16'h0118;
    localparam logic [15:0] ADDR_KP2     = 16'h011C;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t                       state_r, state_n;
    logic signed [GAINBITS-1:0]   tgt_kp_r, tgt_kp2_r;
    logic [GAINBITS-2:0]          step_r;
    logic [31:0]                  ival_r, cnt_r, cnt_n, ival_s;
    logic                         hold_r;
    logic signed [GAINBITS-1:0]   kp_r, kp2_r, kp_n, kp2_n;
    logic signed [GAINBITS-1:0]   step_kp_s, step_kp2_s;
    logic                         busy_r, done_r, done_n, upd_r, upd_n;
    logic                         ack_r;
    logic [31:0]                  rdata_r, rd_mux_s;
    logic                         start_s, abort_s, at_tgt_s;

    // Move cur toward tgt by min(stp,|tgt-cur|) using one guard bit; stp==0 jumps.
    function automatic logic signed [GAINBITS-1:0] ramp_gain(
        input logic signed [GAINBITS-1:0] cur,
        input logic signed [GAINBITS-1:0] tgt,
        input logic [GAINBITS-2:0]        stp
    );
        logic signed [GAINBITS:0] diff;
        logic [GAINBITS:0]        mag;
        logic [GAINBITS:0]        stp_ext;
        diff    = {tgt[GAINBITS-1], tgt} - {cur[GAINBITS-1], cur};
        mag     = diff[GAINBITS] ? $unsigned(-diff) : $unsigned(diff);
        stp_ext = {2'b00, stp};
        if ((stp == {(GAINBITS-1){1'b0}}) || (mag <= stp_ext)) begin
            ramp_gain = tgt;
        end else if (diff[GAINBITS]) begin
            ramp_gain = cur - stp_ext[GAINBITS-1:0];
        end else begin
            ramp_gain = cur + stp_ext[GAINBITS-1:0];
        end
    endfunction

    assign start_s    = wen && (addr == ADDR_CTRL) && wdata[0];
    assign abort_s    = wen && (addr == ADDR_CTRL) && wdata[1];
    assign ival_s     = (ival_r == 32'd0) ? 32'd1 : ival_r;
    assign at_tgt_s   = (kp_r == tgt_kp_r) && (kp2_r == tgt_kp2_r);
    assign step_kp_s  = ramp_gain(kp_r, tgt_kp_r, step_r);
    assign step_kp2_s = ramp_gain(kp2_r, tgt_kp2_r, step_r);

    // Programmable registers written from the bus.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tgt_kp_r  <= {GAINBITS{1'b0}};
            tgt_kp2_r <= {GAINBITS{1'b0}};
            step_r    <= {(GAINBITS-1){1'b0}};
            ival_r    <= 32'(DEFAULT_INTERVAL);
            hold_r    <= 1'b0;
        end else if (wen) begin
            case (addr)
                ADDR_TGT_KP:  tgt_kp_r  <= wdata[GAINBITS-1:0];
                ADDR_TGT_KP2: tgt_kp2_r <= wdata[GAINBITS-1:0];
                ADDR_STEP:    step_r    <= wdata[GAINBITS-2:0];
                ADDR_IVAL:    ival_r    <= wdata;
                ADDR_CTRL:    hold_r    <= wdata[2];
                default:      hold_r    <= hold_r;
            endcase
        end
    end

    // Read data selection; gains are sign-extended, unmapped addresses read zero.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (addr)
            ADDR_TGT_KP:  rd_mux_s = {{(32-GAINBITS){tgt_kp_r[GAINBITS-1]}}, tgt_kp_r};
            ADDR_TGT_KP2: rd_mux_s = {{(32-GAINBITS){tgt_kp2_r[GAINBITS-1]}}, tgt_kp2_r};
            ADDR_STEP:    rd_mux_s = {{(33-GAINBITS){1'b0}}, step_r};
            ADDR_IVAL:    rd_mux_s = ival_r;
            ADDR_CTRL:    rd_mux_s = {29'd0, hold_r, 2'b00};
            ADDR_STATUS:  rd_mux_s = {30'd0, done_r, busy_r};
            ADDR_KP:      rd_mux_s = {{(32-GAINBITS){kp_r[GAINBITS-1]}}, kp_r};
            ADDR_KP2:     rd_mux_s = {{(32-GAINBITS){kp2_r[GAINBITS-1]}}, kp2_r};
            default:      rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Bus acknowledge and read data, registered together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_r   <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else begin
            ack_r   <= wen | ren;
            rdata_r <= ren ? rd_mux_s : 32'h0000_0000;
        end
    end

    // Ramp FSM next-state and datapath; abort outranks start, start while busy restarts.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        kp_n    = kp_r;
        kp2_n   = kp2_r;
        done_n  = done_r;
        upd_n   = 1'b0;
        if (abort_s) begin
            state_n = IDLE;
            done_n  = 1'b0;
        end else if (start_s && (state_r != IDLE)) begin
            state_n = WAIT;
            cnt_n   = ival_s;
            done_n  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s && at_tgt_s) begin
                        done_n = 1'b1;
                    end else if (start_s) begin
                        cnt_n   = ival_s;
                        done_n  = 1'b0;
                        state_n = WAIT;
                    end else begin
                        state_n = IDLE;
                    end
                end
                WAIT: begin
                    if (hold_r) begin
                        cnt_n = cnt_r;
                    end else if (cnt_r <= 32'd1) begin
                        state_n = STEP;
                    end else begin
                        cnt_n = cnt_r - 32'd1;
                    end
                end
                STEP: begin
                    kp_n  = step_kp_s;
                    kp2_n = step_kp2_s;
                    upd_n = (step_kp_s != kp_r) || (step_kp2_s != kp2_r);
                    if ((step_kp_s == tgt_kp_r) && (step_kp2_s == tgt_kp2_r)) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        cnt_n   = ival_s;
                        state_n = WAIT;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // FSM state, live gains and status flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            cnt_r   <= 32'd0;
            kp_r    <= {GAINBITS{1'b0}};
            kp2_r   <= {GAINBITS{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            upd_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            kp_r    <= kp_n;
            kp2_r   <= kp2_n;
            busy_r  <= (state_n != IDLE);
            done_r  <= done_n;
            upd_r   <= upd_n;
        end
    end

    assign ack    = ack_r;
    assign rdata  = rdata_r;
    assign kp_o   = kp_r;
    assign kp2_o  = kp2_r;
    assign busy_o = busy_r;
    assign done_o = done_r;
    assign upd_o  = upd_r;

endmodule

// File: tb/tb_haze_gain_ramp_ctrl.sv
// Self-checking bench for haze_gain_ramp_ctrl: register table, directed ramps,
// hold/abort/reset corner cases and randomized ramps against an arithmetic model.
module tb_haze_gain_ramp_ctrl;

    logic               clk = 1'b0;
    logic               rst;
    logic [15:0]        addr;
    logic               wen, ren;
    logic [31:0]        wdata;
    logic               ack;
    logic [31:0]        rdata;
    logic signed [23:0] kp, kp2;
    logic               busy, done, upd;

    int n_chk  = 0;
    int n_fail = 0;

    longint q1[$];
    longint q2[$];

    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[13];

    haze_gain_ramp_ctrl #(.GAINBITS(24), .DEFAULT_INTERVAL(1000)) dut (
        .clk_i(clk), .rst_i(rst), .addr(addr), .wen(wen), .ren(ren), .wdata(wdata),
        .ack(ack), .rdata(rdata), .kp_o(kp), .kp2_o(kp2),
        .busy_o(busy), .done_o(done), .upd_o(upd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One ramp step of the reference: move toward t by at most s; s==0 jumps.
    function automatic longint move_toward(input longint c, input longint t, input longint s);
        longint d;
        d = t - c;
        if (s == 0 || (d < 0 ? -d : d) <= s) return t;
        return (d > 0) ? c + s : c - s;
    endfunction

    task automatic model_ramp(input longint c1, input longint t1,
                              input longint c2, input longint t2, input longint s);
        q1.delete();
        q2.delete();
        while (c1 != t1 || c2 != t2) begin
            c1 = move_toward(c1, t1, s);
            c2 = move_toward(c2, t2, s);
            q1.push_back(c1);
            q2.push_back(c2);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
        check("read ack", ack, 1);
        d = rdata;
    endtask

    // Called right after the start write; walks every cycle of the expected ramp in q1/q2.
    task automatic ramp_check(input string tag, input int ival, input longint s1, input longint s2);
        int per;
        int n;
        per = ((ival < 1) ? 1 : ival) + 1;
        n   = q1.size();
        for (int c = 1; c <= per * n + 1; c++) begin
            int k, kk;
            longint e1, e2;
            @(negedge clk);
            k  = c / per;
            kk = (k > n) ? n : k;
            e1 = (kk == 0) ? s1 : q1[kk-1];
            e2 = (kk == 0) ? s2 : q2[kk-1];
            check({tag, " kp_o"}, kp, e1);
            check({tag, " kp2_o"}, kp2, e2);
            check({tag, " upd_o"}, upd, ((c % per) == 0 && k >= 1 && k <= n) ? 1 : 0);
            check({tag, " busy_o"}, busy, (k < n) ? 1 : 0);
            check({tag, " done_o"}, done, (k >= n) ? 1 : 0);
        end
    endtask

    logic [31:0] rd;
    longint      mk1, mk2, t1, t2, s;
    int          iv;

    initial begin
        rst = 1'b1; addr = 16'h0; wen = 1'b0; ren = 1'b0; wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst kp_o", kp, 0);
        check("rst kp2_o", kp2, 0);
        check("rst busy_o", busy, 0);
        check("rst done_o", done, 0);
        check("rst upd_o", upd, 0);
        check("rst ack", ack, 0);
        check("rst rdata", rdata, 0);
        rst = 1'b0;

        tbl[0]  = '{1'b0, 16'h010C, 32'h0000_0000, 32'd1000};
        tbl[1]  = '{1'b0, 16'h0114, 32'h0000_0000, 32'h0000_0000};
        tbl[2]  = '{1'b1, 16'h0100, 32'h00FF_FFFF, 32'hFFFF_FFFF};
        tbl[3]  = '{1'b1, 16'h0104, 32'h1234_5678, 32'h0034_5678};
        tbl[4]  = '{1'b1, 16'h0108, 32'hFFFF_FFFF, 32'h007F_FFFF};
        tbl[5]  = '{1'b1, 16'h010C, 32'h0000_0000, 32'h0000_0000};
        tbl[6]  = '{1'b1, 16'h0110, 32'h0000_0004, 32'h0000_0004};
        tbl[7]  = '{1'b1, 16'h0110, 32'h0000_0000, 32'h0000_0000};
        tbl[8]  = '{1'b1, 16'h0118, 32'h0000_0055, 32'h0000_0000};
        tbl[9]  = '{1'b1, 16'h011C, 32'h0000_0055, 32'h0000_0000};
        tbl[10] = '{1'b1, 16'h0124, 32'h0000_DEAD, 32'h0000_0000};
        tbl[11] = '{1'b0, 16'h0000, 32'h0000_0000, 32'h0000_0000};
        tbl[12] = '{1'b1, 16'h0110, 32'h0000_0002, 32'h0000_0000};
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].wr) bus_write(tbl[i].a, tbl[i].d);
            bus_read(tbl[i].a, rd);
            check($sformatf("reg vec %0d rdata", i), rd, tbl[i].exp);
        end

        // Positive ramp
        bus_write(16'h0100, 32'd100);
        bus_write(16'h0104, 32'd0);
        bus_write(16'h0108, 32'd30);
        bus_write(16'h010C, 32'd4);
        bus_write(16'h0110, 32'h1);
        q1 = '{30, 60, 90, 100}; q2 = '{0, 0, 0, 0};
        ramp_check("pos", 4, 0, 0);

        // Jump to 10 with step 0
        bus_write(16'h0100, 32'd10);
        bus_write(16'h0108, 32'd0);
        bus_write(16'h0110, 32'h1);
        q1 = '{10}; q2 = '{0};
        ramp_check("jump", 4, 100, 0);

        // Negative / mixed ramp
        bus_write(16'h0104, 32'hFFFF_FFCE);
        bus_write(16'h0108, 32'd20);
        bus_write(16'h010C, 32'd1);
        bus_write(16'h0110, 32'h1);
        q1 = '{10, 10, 10}; q2 = '{-20, -40, -50};
        ramp_check("neg", 1, 10, 0);

        // Extremes
        bus_write(16'h0100, 32'hFF80_0000);
        bus_write(16'h0108, 32'd0);
        bus_write(16'h0110, 32'h1);
        q1 = '{-8388608}; q2 = '{-50};
        ramp_check("xjump", 1, 10, -50);
        bus_write(16'h0100, 32'd8388607);
        bus_write(16'h0108, 32'd8388607);
        bus_write(16'h0110, 32'h1);
        q1 = '{-1, 8388606, 8388607}; q2 = '{-50, -50, -50};
        ramp_check("xtrm", 1, -8388608, -50);

        // Hold freezes the countdown; release resumes from the frozen count
        bus_write(16'h0100, 32'd8388507);
        bus_write(16'h0108, 32'd10);
        bus_write(16'h010C, 32'd3);
        bus_write(16'h0110, 32'h1);
        bus_write(16'h0110, 32'h4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold kp_o", kp, 8388607);
            check("hold upd_o", upd, 0);
            check("hold busy_o", busy, 1);
        end
        bus_write(16'h0110, 32'h0);
        @(negedge clk);
        check("resume kp_o early", kp, 8388607);
        check("resume upd_o early", upd, 0);
        @(negedge clk);
        check("resume kp_o", kp, 8388597);
        check("resume upd_o", upd, 1);

        // Abort mid-ramp
        bus_write(16'h0110, 32'h2);
        check("abort busy_o", busy, 0);
        check("abort kp_o", kp, 8388597);
        check("abort done_o", done, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post-abort kp_o", kp, 8388597);
            check("post-abort busy_o", busy, 0);
        end

        // Status read while busy
        bus_write(16'h010C, 32'd10);
        bus_write(16'h0110, 32'h1);
        bus_read(16'h0114, rd);
        check("status busy rdata", rd, 1);
        bus_write(16'h0110, 32'h2);
        check("abort2 busy_o", busy, 0);
        check("abort2 kp_o", kp, 8388597);

        // Start with gains already at target
        bus_write(16'h0100, 32'd8388597);
        bus_write(16'h0110, 32'h1);
        q1.delete(); q2.delete();
        ramp_check("attgt", 10, 8388597, -50);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("attgt busy_o", busy, 0);
            check("attgt done_o", done, 1);
        end

        // Randomized ramps against the arithmetic model
        mk1 = 8388597; mk2 = -50;
        for (int t = 0; t < 15; t++) begin
            t1 = longint'(int'($urandom) >>> 8);
            t2 = longint'(int'($urandom) >>> 8);
            if (t == 5) begin t1 = mk1; t2 = mk2; end
            s  = ($urandom_range(0, 4) == 0) ? 0 : longint'($urandom_range(524288, 8388607));
            iv = $urandom_range(0, 4);
            bus_write(16'h0100, 32'(t1));
            bus_write(16'h0104, 32'(t2));
            bus_write(16'h0108, 32'(s));
            bus_write(16'h010C, 32'(iv));
            bus_write(16'h0110, 32'h1);
            model_ramp(mk1, t1, mk2, t2, s);
            ramp_check($sformatf("rnd%0d", t), iv, mk1, mk2);
            mk1 = t1; mk2 = t2;
        end

        // Asynchronous reset in the middle of a long WAIT
        bus_write(16'h0100, 32'd12345);
        bus_write(16'h0108, 32'd0);
        bus_write(16'h010C, 32'd2);
        bus_write(16'h0110, 32'h1);
        model_ramp(mk1, 12345, mk2, mk2, 0);
        ramp_check("prerst", 2, mk1, mk2);
        bus_write(16'h0100, 32'd0);
        bus_write(16'h010C, 32'd100);
        bus_write(16'h0110, 32'h1);
        @(negedge clk);
        addr = 16'h0114; ren = 1'b1;
        @(posedge clk);
        #2;
        check("prerst ack", ack, 1);
        check("prerst busy_o", busy, 1);
        check("prerst kp_o", kp, 12345);
        rst = 1'b1;
        #1;
        check("async rst kp_o", kp, 0);
        check("async rst busy_o", busy, 0);
        check("async rst ack", ack, 0);
        check("async rst rdata", rdata, 0);
        @(negedge clk);
        ren = 1'b0;
        rst = 1'b0;
        bus_read(16'h010C, rd);
        check("post-rst interval", rd, 1000);
        check("post-rst kp_o", kp, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
